vx_warp_ibuffer: RTL

Per-warp instruction buffer between decode and the dispatch/demux stage. Decode pushes one instruction per cycle tagged with its warp id. Each warp has its own small circular FIFO. A round-robin selector presents one warp's head instruction per cycle downstream over a valid/ready handshake. This decouples per-warp stalls, so one blocked warp does not block the others.

---
 rtl/vx_warp_ibuffer_pkg.sv | 32 +++
 rtl/vx_warp_ibuffer_rr_arbiter.sv | 48 ++++
 rtl/vx_warp_ibuffer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vx_warp_ibuffer_pkg.sv
// ---------------------------------------------------------------------------
// vx_warp_ibuffer_pkg
// Shared constants for the per-warp instruction buffer. These are the machine
// configuration and the decoded-instruction field widths that together form
// the opaque payload carried from decode to dispatch.
// ---------------------------------------------------------------------------
package vx_warp_ibuffer_pkg;

  // Machine configuration
  localparam int IBUF_NUM_THREADS = 4;
  localparam int IBUF_NUM_WARPS   = 4;
  localparam int IBUF_NW_BITS     = $clog2(IBUF_NUM_WARPS);
  localparam int IBUF_DEPTH       = 2;

  // Decoded instruction fields, packed in this order into the payload
  localparam int TMASK_BITS   = IBUF_NUM_THREADS;
  localparam int PC_BITS      = 32;
  localparam int EX_TYPE_BITS = 2;
  localparam int OP_TYPE_BITS = 4;
  localparam int OP_MOD_BITS  = 3;
  localparam int WB_BITS      = 1;
  localparam int USE_PC_BITS  = 1;
  localparam int USE_IMM_BITS = 1;
  localparam int REG_BITS     = 5;   // rd, rs1, rs2, rs3 each
  localparam int IMM_BITS     = 32;
  localparam int UUID_BITS    = 28;

  localparam int IBUF_DATAW = TMASK_BITS + PC_BITS + EX_TYPE_BITS + OP_TYPE_BITS
                            + OP_MOD_BITS + WB_BITS + USE_PC_BITS + USE_IMM_BITS
                            + 4 * REG_BITS + IMM_BITS + UUID_BITS;

endpackage

// File: rtl/vx_warp_ibuffer_rr_arbiter.sv
// ---------------------------------------------------------------------------
// vx_rr_arbiter
// Purely combinational round-robin selector over N request lines.
//   requests    : one request bit per candidate
//   rr_ptr      : highest-priority candidate this cycle
//   lock        : when set, the grant is pinned to lock_idx regardless of
//                 requests (used to hold a stalled handshake stable)
//   lock_idx    : index held while lock is set
//   grant_idx   : selected candidate (0 when nothing is granted)
//   grant_valid : a candidate is granted
// N must be a power of two so index arithmetic wraps modulo N for free.
// ---------------------------------------------------------------------------
module vx_rr_arbiter #(
  parameter int N    = 4,
  parameter int LOGN = $clog2(N)
) (
  input  logic [N-1:0]    requests,
  input  logic [LOGN-1:0] rr_ptr,
  input  logic            lock,
  input  logic [LOGN-1:0] lock_idx,
  output logic [LOGN-1:0] grant_idx,
  output logic            grant_valid
);

  logic [LOGN-1:0] idx;

  // NOTE: every variable driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    if (lock) begin
      grant_idx   = lock_idx;
      grant_valid = 1'b1;
    end else begin
      // Scan from rr_ptr upward; the first hit wins.
      for (int i = 0; i < N; i++) begin
        idx = rr_ptr + LOGN'(i);
        if (!grant_valid && requests[idx]) begin
          grant_idx   = idx;
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vx_warp_ibuffer.sv
// ---------------------------------------------------------------------------
// vx_warp_ibuffer
// Per-warp instruction buffer between decode and dispatch. Each warp owns a
// small circular FIFO; a round-robin arbiter presents one warp head per cycle
// so a stalled warp never blocks the others.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_wid/in_data, in_ready    : push from decode into warp in_wid
//   out_valid/out_wid/out_data, out_ready: head of the granted warp downstream
//   empty_mask / full_mask: per-warp occupancy flags from registered counts
// ---------------------------------------------------------------------------
module vx_warp_ibuffer
  import vx_warp_ibuffer_pkg::*;
#(
  parameter int NUM_WARPS = IBUF_NUM_WARPS,
  parameter int DEPTH     = IBUF_DEPTH,
  parameter int DATAW     = IBUF_DATAW,
  parameter int NW_BITS   = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [NW_BITS-1:0]   in_wid,
  input  logic [DATAW-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [NW_BITS-1:0]   out_wid,
  output logic [DATAW-1:0]     out_data,
  input  logic                 out_ready,
  output logic [NUM_WARPS-1:0] empty_mask,
  output logic [NUM_WARPS-1:0] full_mask
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PTRW = $clog2(DEPTH);

  logic [DATAW-1:0]   mem    [NUM_WARPS][DEPTH];
  logic [CNTW-1:0]    count  [NUM_WARPS];
  logic [PTRW-1:0]    rd_ptr [NUM_WARPS];
  logic [PTRW-1:0]    wr_ptr [NUM_WARPS];
  logic [NW_BITS-1:0] rr_ptr;
  logic               lock;
  logic [NW_BITS-1:0] lock_wid;

  logic               push;
  logic               pop;
  logic [NW_BITS-1:0] grant_idx;
  logic               grant_valid;
  logic [NUM_WARPS-1:0] push_vec;
  logic [NUM_WARPS-1:0] pop_vec;

  always_comb begin
    empty_mask = '0;
    full_mask  = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      empty_mask[w] = (count[w] == '0);
      full_mask[w]  = (count[w] == CNTW'(DEPTH));
    end
  end

  // Depends only on registered counts: a full warp stays closed even when its
  // head is leaving this cycle, keeping out_ready off the in_ready path.
  assign in_ready = !full_mask[in_wid];
  assign push     = in_valid && in_ready;

  vx_rr_arbiter #(
    .N    (NUM_WARPS),
    .LOGN (NW_BITS)
  ) u_rr_arbiter (
    .requests    (~empty_mask),
    .rr_ptr      (rr_ptr),
    .lock        (lock),
    .lock_idx    (lock_wid),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign out_valid = grant_valid;
  assign out_wid   = grant_valid ? grant_idx : '0;
  assign out_data  = grant_valid ? mem[grant_idx][rd_ptr[grant_idx]] : '0;
  assign pop       = grant_valid && out_ready;

  always_comb begin
    push_vec = '0;
    pop_vec  = '0;
    if (push) push_vec[in_wid]   = 1'b1;
    if (pop)  pop_vec[grant_idx] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every update in this
  // block sees the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        count[w]  <= '0;
        rd_ptr[w] <= '0;
        wr_ptr[w] <= '0;
      end
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_wid <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (push_vec[w]) wr_ptr[w] <= wr_ptr[w] + PTRW'(1);
        if (pop_vec[w])  rd_ptr[w] <= rd_ptr[w] + PTRW'(1);
        case ({push_vec[w], pop_vec[w]})
          2'b10:   count[w] <= count[w] + CNTW'(1);
          2'b01:   count[w] <= count[w] - CNTW'(1);
          default: ;
        endcase
      end

      if (pop) begin
        lock   <= 1'b0;
        rr_ptr <= grant_idx + NW_BITS'(1);
      end else if (grant_valid) begin
        // Stalled handshake: pin the grant until it is consumed.
        lock     <= 1'b1;
        lock_wid <= grant_idx;
      end
    end
  end

  // NOTE: payload storage is deliberately not reset; an entry is only ever
  // observed once count says it was written, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem[in_wid][wr_ptr[in_wid]] <= in_data;
  end

endmodule
